main_memory_responder: RTL and testbench
========================================

# main_memory_responder

Word-addressed backing-store model that answers the line-fill requests a cache controller issues on a miss, replacing the fixed dummy memory word with a real, writable array. It sits below the L2 of the two-level cache system as the memory end of the request/response interface. It provides:
- a single-outstanding valid/ready request channel;
- a programmable fixed access latency;
- a valid/ready response channel with backpressure;
- a post-reset initialisation sweep that fills every word with a known value.

## Interface
- ADDR_WIDTH, 11, word address width; MEM_DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- LATENCY, 4, cycles from request acceptance to response valid; legal range 1..255.
- INIT_VALUE, 32'h000003F3, value written to every word by the init sweep.
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder accepts a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data; ignored for reads.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_data  output  DATA_WIDTH  read data; 0 for write responses.
- init_done  output  1  init sweep complete; stays high until the next reset.

## Operation
- States: INIT, IDLE, WAIT, RESP.
- Reset (rst_n low): state INIT, init pointer 0, latency counter 0.
  - Reset values: req_ready=0, resp_valid=0, resp_data=0, init_done=0.
  - The array itself is not reset.
- INIT
  - Each clock writes INIT_VALUE to mem[ptr], then ptr+1.
  - When ptr = MEM_DEPTH-1 is written: go to IDLE and set init_done=1.
  - req_ready is 0 throughout INIT.
- IDLE
  - req_ready=1.
  - A request is accepted when req_valid && req_ready at a clock edge.
  - Read: the array word is latched into the response register at the acceptance edge.
  - Write: mem[req_addr] <= req_wdata at the acceptance edge, and the response register is loaded with 0.
  - The counter is loaded with LATENCY-1, then the state moves to WAIT.
- WAIT
  - req_ready=0.
  - Counter decrements each clock; when it is 0 at an edge, go to RESP.
- RESP
  - resp_valid=1, and resp_data is held stable.
  - On resp_valid && resp_ready at an edge: resp_valid=0, go to IDLE.
  - resp_ready low holds RESP indefinitely.
- Only one request is outstanding at a time. req_* inputs are ignored outside IDLE.
- Read-after-write to the same address returns the new data, because the write commits at acceptance.

## Timing
- Sweep duration: the first edge with rst_n high writes address 0. req_ready and init_done rise after edge MEM_DEPTH (2048 cycles at the default).
- Acceptance at edge T: resp_valid is high after edge T+LATENCY.
- Earliest response handshake is edge T+LATENCY+1. req_ready is high again after that edge.
- Minimum request-to-request spacing is LATENCY+2 cycles.
- Same-cycle response handshake and new request acceptance is impossible (req_ready=0 in RESP).
- Asynchronous reset mid-INIT/WAIT/RESP:
  - outputs drop immediately to their reset values;
  - any pending response is discarded;
  - a write already accepted stays committed, until the sweep restarts and overwrites it.
- All outputs are registered. No combinational input-to-output path; req_ready is decoded from the state register only.

## Test plan
- Init sweep: release rst_n.
  - req_ready=0 and init_done=0 for 2048 cycles, then both high.
  - Read of addresses 0x000, 0x3FF and 0x7FF each returns 32'h000003F3.
- Write/read: write 0xDEADBEEF to 0x123, then read 0x123.
  - Read response is 0xDEADBEEF.
  - Write response has resp_data=0.
  - Read of 0x124 still returns 0x3F3.
- Latency: accept a read at edge T with LATENCY=4.
  - resp_valid=0 through edge T+3 and 1 after edge T+4.
  - Repeat with LATENCY=1: resp_valid after edge T+1.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid rises.
  - resp_valid and resp_data stay stable and req_ready stays 0.
  - Raise resp_ready: one handshake occurs, and req_ready=1 in the next cycle.
- Reset mid-operation: assert rst_n low while in WAIT.
  - Outputs immediately go to 0.
  - After release, the sweep reruns, and a previously written 0xDEADBEEF at 0x123 reads back as 0x3F3.
- Ignored inputs: drive req_valid=1 with varying addresses during INIT, WAIT and RESP.
  - No extra responses are produced.
  - Array contents are unchanged, verified by readback.

Source files
------------

// File: rtl/main_memory_responder_if.sv
// Request/response bus between a cache controller (master) and the backing-store responder (slave).
// The interface also carries the responder's init_done status flag.
interface main_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, init_done
  );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed backing store answering single-outstanding cache line-fill requests.
// After reset it sweeps INIT_VALUE into every word, then serves requests with fixed latency.
module main_memory_responder #(
  parameter int unsigned          ADDR_WIDTH = 11,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          LATENCY    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 32'h0000_03F3
) (
  input logic                    clk,
  input logic                    rst_n,
  main_memory_responder_if.slave bus
);
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [7:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_accept;
  logic                  w_init_last;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_init_last = (r_ptr == {ADDR_WIDTH{1'b1}});

  // Single write port shared by the init sweep and accepted write requests.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_ptr;
    w_mem_wdata = INIT_VALUE;
    if (r_state == ST_INIT) begin
      w_mem_we = 1'b1;
    end else if (w_accept && bus.req_we) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = bus.req_addr;
      w_mem_wdata = bus.req_wdata;
    end
  end

  // Array is intentionally not reset; the sweep gives it a known value.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_ptr <= r_ptr + ADDR_WIDTH'(1);
          if (w_init_last) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            // Read data is captured at acceptance, so a later write cannot disturb it.
            r_resp_data <= bus.req_we ? '0 : r_mem[bus.req_addr];
            r_cnt       <= 8'(LATENCY - 1);
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_data  = r_resp_data;
  assign bus.init_done  = r_init_done;
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_main_memory_responder;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  main_memory_responder_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus0 ();
  main_memory_responder_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus1 ();

  main_memory_responder #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .LATENCY(4), .INIT_VALUE(32'h0000_03F3)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  main_memory_responder #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .LATENCY(1), .INIT_VALUE(32'h0000_03F3)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic we, input logic [10:0] addr,
                       input logic [31:0] wd);
    if (sel) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr; bus1.req_wdata = wd;
    end else begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr; bus0.req_wdata = wd;
    end
  endtask

  task automatic set_rready(input bit sel, input logic r);
    if (sel) bus1.resp_ready = r;
    else     bus0.resp_ready = r;
  endtask

  function automatic logic rv(input bit sel);
    return sel ? bus1.resp_valid : bus0.resp_valid;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? bus1.req_ready : bus0.req_ready;
  endfunction

  function automatic logic [31:0] rd(input bit sel);
    return sel ? bus1.resp_data : bus0.resp_data;
  endfunction

  // Called #1 after a rising edge with dut in IDLE. Returns data and edges from accept to valid.
  task automatic do_req(input bit sel, input logic we, input logic [10:0] addr,
                        input logic [31:0] wd, input int hold, input bit junk,
                        output logic [31:0] data, output int lat);
    check("ready_before_req", 32'(rdy(sel)), 32'd1);
    drive(sel, 1'b1, we, addr, wd);
    @(posedge clk); #1;
    lat = 0;
    if (junk) drive(sel, 1'b1, 1'b1, 11'h200, 32'h1111_1111);
    else      drive(sel, 1'b0, 1'b0, 11'h0, 32'h0);
    while (!rv(sel) && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (junk) drive(sel, 1'b1, 1'b1, 11'h200 + 11'(lat), 32'h1111_1111);
    end
    if (lat >= 300) check("resp_timeout", 32'(rv(sel)), 32'd1);
    data = rd(sel);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (junk) drive(sel, 1'b1, 1'b1, 11'h200 + 11'(k), 32'h1111_1111);
      check("bp_valid", 32'(rv(sel)), 32'd1);
      check("bp_data", rd(sel), data);
      check("bp_ready", 32'(rdy(sel)), 32'd0);
    end
    drive(sel, 1'b0, 1'b0, 11'h0, 32'h0);
    set_rready(sel, 1'b1);
    @(posedge clk); #1;
    set_rready(sel, 1'b0);
    check("post_hs_valid", 32'(rv(sel)), 32'd0);
    check("post_hs_ready", 32'(rdy(sel)), 32'd1);
  endtask

  // Called #1 after the edge on which rst_n was released; optionally drives junk into dut0.
  task automatic wait_sweep(input bit junk);
    int i;
    int spurious;
    i = 0;
    spurious = 0;
    while (!bus0.req_ready && i < 3000) begin
      if (junk && i < 2000) drive(1'b0, 1'b1, 1'b1, 11'(i * 7), 32'h5555_5555);
      else                  drive(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
      @(posedge clk); #1;
      i++;
      if (bus0.resp_valid) spurious++;
      if (i == 2047) check("init_done_early", 32'(bus0.init_done), 32'd0);
    end
    check("sweep_len", 32'(i), 32'd2048);
    check("init_done", 32'(bus0.init_done), 32'd1);
    check("init_done_lat1", 32'(bus1.init_done), 32'd1);
    check("init_spurious", 32'(spurious), 32'd0);
  endtask

  initial begin
    logic [31:0] data;
    int          lat;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 11'h0, 32'h0);
    set_rready(1'b0, 1'b0);
    set_rready(1'b1, 1'b0);
    #2;
    check("rst_req_ready", 32'(bus0.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_resp_data", bus0.resp_data, 32'd0);
    check("rst_init_done", 32'(bus0.init_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_sweep(1'b1);

    do_req(1'b0, 1'b0, 11'h000, 32'h0, 0, 1'b0, data, lat);
    check("rd_000", data, 32'h0000_03F3);
    check("lat4", 32'(lat), 32'd4);
    do_req(1'b0, 1'b0, 11'h3FF, 32'h0, 0, 1'b0, data, lat);
    check("rd_3ff", data, 32'h0000_03F3);
    do_req(1'b0, 1'b0, 11'h7FF, 32'h0, 0, 1'b0, data, lat);
    check("rd_7ff", data, 32'h0000_03F3);

    do_req(1'b0, 1'b1, 11'h123, 32'hDEAD_BEEF, 0, 1'b0, data, lat);
    check("wr_resp_data", data, 32'h0);
    check("wr_lat", 32'(lat), 32'd4);
    do_req(1'b0, 1'b0, 11'h123, 32'h0, 0, 1'b0, data, lat);
    check("rd_123", data, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b0, 11'h124, 32'h0, 0, 1'b0, data, lat);
    check("rd_124", data, 32'h0000_03F3);

    do_req(1'b1, 1'b0, 11'h7FF, 32'h0, 0, 1'b0, data, lat);
    check("lat1_data", data, 32'h0000_03F3);
    check("lat1", 32'(lat), 32'd1);

    // Backpressure with junk requests during WAIT and RESP.
    do_req(1'b0, 1'b0, 11'h123, 32'h0, 10, 1'b1, data, lat);
    check("bp_rd_data", data, 32'hDEAD_BEEF);
    check("bp_lat", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no_extra_resp", 32'(bus0.resp_valid), 32'd0);
    end
    do_req(1'b0, 1'b0, 11'h200, 32'h0, 0, 1'b0, data, lat);
    check("junk_200", data, 32'h0000_03F3);
    do_req(1'b0, 1'b0, 11'h205, 32'h0, 0, 1'b0, data, lat);
    check("junk_205", data, 32'h0000_03F3);

    // Reset while dut0 is in WAIT with a read of 0x123 pending.
    check("pre_rst_ready", 32'(bus0.req_ready), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 11'h123, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 11'h0, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus0.req_ready), 32'd0);
    check("mid_rst_valid", 32'(bus0.resp_valid), 32'd0);
    check("mid_rst_data", bus0.resp_data, 32'd0);
    check("mid_rst_done", 32'(bus0.init_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_sweep(1'b0);
    do_req(1'b0, 1'b0, 11'h123, 32'h0, 0, 1'b0, data, lat);
    check("rd_123_after_rst", data, 32'h0000_03F3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
